if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 167 ++++++++++++++++
 tb/tb_if_stage.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with single-outstanding memory port and 2-entry output FIFO
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pc
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [31:0] fetch_pc;

    // Head entry drives the decode outputs; skid entry absorbs one more response.
    logic        head_v;
    logic [31:0] head_instr;
    logic [31:0] head_pc;
    logic        skid_v;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc;

    // Responses still owed for requests issued before a reset; they are
    // swallowed ahead of any response the current state is waiting for.
    logic [1:0]  drop_cnt;
    logic [1:0]  outst;
    logic [1:0]  rst_drop;

    logic        consume;
    logic        full_after;
    logic        granted;
    logic        beat;
    logic        capture;

    assign consume     = head_v & id_ready;
    assign full_after  = head_v & skid_v & ~id_ready;
    assign granted     = imem_req & imem_gnt;
    assign beat        = imem_rvalid & (drop_cnt == 2'd0);

    assign imem_addr   = fetch_pc;
    assign instr_valid = head_v;
    assign instr       = head_v ? head_instr : NOP_INSTR;
    assign pc          = head_pc;

    // Next-state, request and capture decisions; redirect overrides the normal flow.
    always_comb begin
        state_n  = state;
        imem_req = 1'b0;
        capture  = 1'b0;
        case (state)
            S_REQ: begin
                imem_req = ~full_after & ~rst;
                if (imem_req && imem_gnt) begin
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (beat) begin
                    state_n = S_REQ;
                    capture = ~redirect_valid;
                end
            end
            S_DROP: begin
                if (beat) begin
                    state_n = S_REQ;
                end
            end
            default: begin
                state_n = S_REQ;
            end
        endcase
        if (redirect_valid) begin
            case (state)
                S_REQ:   state_n = granted ? S_DROP : S_REQ;
                S_WAIT:  state_n = beat ? S_REQ : S_DROP;
                S_DROP:  state_n = beat ? S_REQ : S_DROP;
                default: state_n = S_REQ;
            endcase
        end
    end

    // Count of responses outstanding at a reset edge, less any arriving on that edge.
    always_comb begin
        outst    = drop_cnt + {1'b0, (state != S_REQ)};
        rst_drop = outst;
        if (imem_rvalid && (outst != 2'd0)) begin
            rst_drop = outst - 2'd1;
        end
    end

    // Control state: FSM, fetch address and pre-reset drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_REQ;
            fetch_pc <= RESET_PC;
            drop_cnt <= rst_drop;
        end else begin
            state <= state_n;
            if (imem_rvalid && (drop_cnt != 2'd0)) begin
                drop_cnt <= drop_cnt - 2'd1;
            end
            if (redirect_valid) begin
                fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
            end else if (capture) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
        end
    end

    // Output FIFO: flush on redirect, shift skid into head on consume, fill the first free slot on capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_v     <= 1'b0;
            head_instr <= NOP_INSTR;
            head_pc    <= RESET_PC;
            skid_v     <= 1'b0;
            skid_instr <= NOP_INSTR;
            skid_pc    <= RESET_PC;
        end else if (redirect_valid) begin
            head_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (consume) begin
            if (skid_v) begin
                head_instr <= skid_instr;
                head_pc    <= skid_pc;
                skid_v     <= capture;
                if (capture) begin
                    skid_instr <= imem_rdata;
                    skid_pc    <= fetch_pc;
                end
            end else begin
                head_v <= capture;
                if (capture) begin
                    head_instr <= imem_rdata;
                    head_pc    <= fetch_pc;
                end
            end
        end else if (capture) begin
            if (!head_v) begin
                head_v     <= 1'b1;
                head_instr <= imem_rdata;
                head_pc    <= fetch_pc;
            end else begin
                skid_v     <= 1'b1;
                skid_instr <= imem_rdata;
                skid_pc    <= fetch_pc;
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage with memory model and delivery-order reference
module tb_if_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        id_ready = 1'b0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;

    always #5 clk = ~clk;

    if_stage dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .pc             (pc)
    );

    int tests = 0;
    int fails = 0;

    // memory model: in-order queue of {stale, addr}; stale responses carry poison data
    logic [32:0] q[$];
    int          head_wait = 0;
    int          lat_fixed = 0;
    bit          gnt_rand = 0;
    bit          gnt_off = 0;
    bit          ready_rand = 0;

    // stimulus controls
    logic        d_rst = 1'b1;
    logic        d_redir = 1'b0;
    logic [31:0] d_redir_pc = 32'h0;
    logic        d_ready = 1'b1;

    // reference: next pc decode must see, number of deliveries since reset
    logic [31:0] exp_pc = RESET_PC;
    int          hs_count = 0;
    bit          chk_flush = 0;
    bit          chk_rst_pc = 0;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0050_0093 : (a ^ 32'h1357_9BDF);
    endfunction

    function automatic int next_wait();
        return (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 2));
    endfunction

    function automatic int nonstale();
        int n = 0;
        foreach (q[i]) if (q[i][32] == 1'b0) n++;
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // apply inputs at the negedge, let combinational outputs settle, run per-cycle checks
    task automatic drive();
        logic [32:0] hd;
        rst            = d_rst;
        redirect_valid = d_redir;
        redirect_pc    = d_redir_pc;
        id_ready       = ready_rand ? ($urandom_range(0, 3) != 0) : d_ready;
        imem_gnt       = gnt_off ? 1'b0 : (gnt_rand ? ($urandom_range(0, 9) < 7) : 1'b1);
        imem_rvalid    = (q.size() > 0) && (head_wait == 0);
        if (imem_rvalid) begin
            hd = q[0];
            imem_rdata = hd[32] ? 32'hDEAD_BEEF : memfn(hd[31:0]);
        end else begin
            imem_rdata = $urandom;
        end
        #1;
        if (chk_flush) chk("flush_iv", {31'b0, instr_valid}, 32'd0);
        if (chk_rst_pc) chk("rst_pc_out", pc, RESET_PC);
        if (!instr_valid) chk("nop_when_invalid", instr, NOP_INSTR);
        if (rst) chk("req_in_rst", {31'b0, imem_req}, 32'd0);
        if (imem_req) begin
            chk("one_outstanding", 32'(nonstale()), 32'd0);
            chk("addr_align", {30'b0, imem_addr[1:0]}, 32'd0);
        end
        if (instr_valid && id_ready && !rst && !redirect_valid) begin
            chk("deliver_pc", pc, exp_pc);
            chk("deliver_instr", instr, memfn(exp_pc));
            exp_pc = exp_pc + 32'd4;
            hs_count++;
        end
    endtask

    // advance the memory model and reference past the next rising edge
    task automatic commit();
        bit granted;
        granted = imem_req && imem_gnt;
        if (imem_rvalid) begin
            void'(q.pop_front());
            if (q.size() > 0) head_wait = next_wait();
        end else if (q.size() > 0 && head_wait > 0) begin
            head_wait--;
        end
        if (granted) begin
            q.push_back({1'b0, imem_addr});
            if (q.size() == 1) head_wait = next_wait();
        end
        chk_flush  = 0;
        chk_rst_pc = 0;
        if (rst) begin
            foreach (q[i]) q[i][32] = 1'b1;
            exp_pc     = RESET_PC;
            hs_count   = 0;
            chk_flush  = 1;
            chk_rst_pc = 1;
        end else if (redirect_valid) begin
            foreach (q[i]) q[i][32] = 1'b1;
            exp_pc    = redirect_pc & 32'hFFFF_FFFC;
            chk_flush = 1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step();
        drive();
        commit();
    endtask

    task automatic reset_dut(input int n);
        d_rst   = 1'b1;
        d_redir = 1'b0;
        repeat (n) step();
        d_rst = 1'b0;
    endtask

    initial begin
        int n;
        @(negedge clk);

        // reset state, first fetch, throughput with 1-cycle memory
        lat_fixed = 0;
        d_ready   = 1'b1;
        reset_dut(4);
        drive();
        chk("rst_iv", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr", instr, NOP_INSTR);
        chk("rst_pc", pc, RESET_PC);
        chk("first_req", {31'b0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, RESET_PC);
        commit();
        step();
        drive();
        chk("s1_iv", {31'b0, instr_valid}, 32'd1);
        chk("s1_instr", instr, 32'h0050_0093);
        chk("s1_pc", pc, 32'h0);
        chk("s1_next_addr", imem_addr, 32'h4);
        commit();
        repeat (17) step();
        chk("throughput", 32'(hs_count), 32'd9);

        // stall fills both FIFO slots, then drains in order
        reset_dut(4);
        d_ready = 1'b0;
        repeat (6) step();
        drive();
        chk("full_iv", {31'b0, instr_valid}, 32'd1);
        chk("full_pc", pc, 32'h0);
        chk("full_noreq", {31'b0, imem_req}, 32'd0);
        chk("full_addr", imem_addr, 32'h8);
        commit();
        d_ready = 1'b1;
        repeat (6) step();
        chk("drain_count", 32'(hs_count), 32'd4);

        // redirect while waiting with a valid head entry
        reset_dut(4);
        d_ready   = 1'b0;
        lat_fixed = 0;
        step();
        step();
        lat_fixed = 2;
        step();
        d_redir    = 1'b1;
        d_redir_pc = 32'h0000_0102;
        drive();
        chk("s3_pre_iv", {31'b0, instr_valid}, 32'd1);
        commit();
        d_redir = 1'b0;
        drive();
        chk("s3_iv", {31'b0, instr_valid}, 32'd0);
        chk("s3_drop_noreq", {31'b0, imem_req}, 32'd0);
        chk("s3_addr", imem_addr, 32'h0000_0100);
        commit();
        d_ready   = 1'b1;
        lat_fixed = 0;
        n = 0;
        drive();
        while (!imem_req && n < 10) begin
            commit();
            drive();
            n++;
        end
        chk("s3_refetch_req", {31'b0, imem_req}, 32'd1);
        chk("s3_refetch_addr", imem_addr, 32'h0000_0100);
        commit();
        repeat (5) step();
        chk("s3_count", 32'(hs_count), 32'd2);

        // redirect coincident with the response
        reset_dut(4);
        step();
        d_redir    = 1'b1;
        d_redir_pc = 32'h0000_0200;
        drive();
        chk("s4_rvalid", {31'b0, imem_rvalid}, 32'd1);
        commit();
        d_redir = 1'b0;
        drive();
        chk("s4_iv", {31'b0, instr_valid}, 32'd0);
        chk("s4_req", {31'b0, imem_req}, 32'd1);
        chk("s4_addr", imem_addr, 32'h0000_0200);
        commit();
        repeat (3) step();
        chk("s4_count", 32'(hs_count), 32'd1);

        // address wrap at the top of memory, unaligned redirect target
        reset_dut(4);
        gnt_off    = 1;
        d_redir    = 1'b1;
        d_redir_pc = 32'hFFFF_FFFF;
        step();
        gnt_off = 0;
        d_redir = 1'b0;
        drive();
        chk("wrap_req", {31'b0, imem_req}, 32'd1);
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        commit();
        step();
        drive();
        chk("wrap_iv", {31'b0, instr_valid}, 32'd1);
        chk("wrap_pc", pc, 32'hFFFF_FFFC);
        chk("wrap_instr", instr, 32'hECA8_6423);
        chk("wrap_next_addr", imem_addr, 32'h0);
        commit();

        // reset while waiting; the late response must be ignored
        reset_dut(4);
        lat_fixed = 2;
        step();
        d_rst = 1'b1;
        step();
        d_rst     = 1'b0;
        lat_fixed = 0;
        drive();
        chk("s6_req", {31'b0, imem_req}, 32'd1);
        chk("s6_addr", imem_addr, RESET_PC);
        commit();
        n = 0;
        drive();
        while (!instr_valid && n < 10) begin
            commit();
            drive();
            n++;
        end
        chk("s6_iv", {31'b0, instr_valid}, 32'd1);
        chk("s6_pc", pc, RESET_PC);
        chk("s6_instr", instr, 32'h0050_0093);
        commit();

        // randomized traffic against the reference stream
        reset_dut(4);
        gnt_rand   = 1;
        ready_rand = 1;
        lat_fixed  = -1;
        repeat (3000) begin
            d_rst      = ($urandom_range(0, 199) == 0);
            d_redir    = ($urandom_range(0, 29) == 0);
            d_redir_pc = $urandom;
            if ($urandom_range(0, 3) == 0) d_redir_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
